mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external memory bus between instruction fetch (IF) and data access (MEM).
//  MEM always has priority over IF. Each access is a registered bus transaction completed by bus_ack.
//  Generates stall requests for the pipeline control logic, so IF and MEM stages hold until their data returns.
//  Flush cancels a pending fetch; stores and loads already in flight are never cancelled.
// PARAMETERS
//  ADDR_W   32    bus/requester address width
//  DATA_W   32    bus/requester data width (= `RegBus)
//  TIMEOUT  1023  max bus_req cycles without bus_ack before abort; count width = $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst          in   1       synchronous reset, active-high (`RstEnable = 1'b1)
//  flush        in   1       pipeline flush (exception/branch cancel of fetch)
//  if_req       in   1       fetch request, held until if_ready or flush
//  if_addr      in   ADDR_W  fetch address
//  if_rdata     out  DATA_W  fetched instruction, valid when if_ready
//  if_ready     out  1       one-cycle fetch completion pulse
//  mem_req      in   1       data access request, held until mem_ready
//  mem_we       in   1       1 = store, 0 = load
//  mem_sel      in   4       byte lane enables
//  mem_addr     in   ADDR_W  data address
//  mem_wdata    in   DATA_W  store data
//  mem_rdata    out  DATA_W  load data, valid when mem_ready
//  mem_ready    out  1       one-cycle data completion pulse
//  bus_req      out  1       bus cycle active
//  bus_we       out  1       bus write enable
//  bus_sel      out  4       bus byte enables
//  bus_addr     out  ADDR_W  bus address
//  bus_wdata    out  DATA_W  bus write data
//  bus_rdata    in   DATA_W  bus read data, sampled when bus_ack
//  bus_ack      in   1       bus completion, sampled only while bus_req=1
//  stallreq_if  out  1       combinational: if_req & ~if_ready & ~flush
//  stallreq_mem out  1       combinational: mem_req & ~mem_ready
//  timeout_err  out  1       one-cycle pulse with the ready of an aborted access
// BEHAVIOUR
//  Reset: state=IDLE. All registered outputs = 0: bus_*, if_rdata, mem_rdata (`ZeroWord), readies, timeout_err, count.
//   Reset mid-transaction abandons the bus cycle (bus_req=0 next edge); no ready pulse.
//  FSM states: IDLE, MEM_BUSY, IF_BUSY, IF_DRAIN.
//  IDLE, mem_req=1: latch mem_we/sel/addr/wdata into bus_*, bus_req<=1, ->MEM_BUSY (MEM wins ties).
//  IDLE, mem_req=0 & if_req=1 & flush=0: bus_addr<=if_addr, bus_we<=0, bus_sel<=4'hF, bus_req<=1, ->IF_BUSY.
//  IDLE, if_req & flush: no grant.
//  Ready pulse from the previous access is asserted in IDLE; grants in that cycle ignore the requester just served.
//   No back-to-back re-grant of the same stale request.
//  MEM_BUSY/IF_BUSY on bus_ack: bus_req<=0, requester rdata<=bus_rdata (stores: mem_rdata<=0), ready<=1 for 1 cycle, ->IDLE.
//  IF_BUSY & flush (no ack same cycle): ->IF_DRAIN.
//   flush and bus_ack in the same cycle: data discarded, no if_ready, ->IDLE.
//  IF_DRAIN: hold bus_req until bus_ack, discard data, no if_ready, ->IDLE. stallreq_if=0 while flushed.
//  flush has no effect on MEM_BUSY.
//  Latency: request seen at edge N -> bus_req high from N+1; ack sampled at edge N+k (k>=1) -> ready high after edge N+k.
//   Minimum 2 cycles request-to-ready.
//  Bus outputs stable for the whole of a busy state; requester input changes mid-access are ignored.
//  Timeout: count increments each busy cycle without ack, cleared on grant. Reaching TIMEOUT:
//   bus_req<=0, ready pulse with rdata=0, timeout_err pulse, ->IDLE. In IF_DRAIN timeout: ->IDLE, no pulses.
//  bus_ack while bus_req=0 is ignored.
// TESTING
//  1 mem_req load addr=0x100, ack 3 cycles later, rdata=0xDEADBEEF -> mem_ready 1 cycle, mem_rdata=0xDEADBEEF, stallreq_mem low after pulse.
//  2 if_req and mem_req (store 0x55AA, sel=4'b0011) same cycle -> MEM granted first (bus_we=1, bus_sel=3);
//    after mem_ready, IF granted; if_ready only after second ack.
//  3 IF access pending, flush 1 cycle, ack 2 cycles later -> no if_ready, state returns IDLE, next if_req granted normally.
//  4 zero-wait slave (ack=bus_req) with continuous if_req stream -> if_ready every 3rd cycle, no duplicate grants.
//  5 TIMEOUT=8, never ack load -> after 8 busy cycles bus_req=0, mem_ready & timeout_err pulse, mem_rdata=0.
//  6 rst asserted during MEM_BUSY -> next edge all outputs 0, IDLE, late ack ignored, no ready pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : requester, bus and stall signals of the memory port arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              stallreq_if;
  logic              stallreq_mem;
  logic              timeout_err;

  // Arbiter view
  modport slave (
    input  flush, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready, bus_req, bus_we, bus_sel,
           bus_addr, bus_wdata, stallreq_if, stallreq_mem, timeout_err
  );

  // Pipeline and external memory view
  modport master (
    output flush, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready, bus_req, bus_we, bus_sel,
           bus_addr, bus_wdata, stallreq_if, stallreq_mem, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one memory bus between fetch (IF) and data (MEM)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    port
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    IF_BUSY  = 2'd2,
    IF_DRAIN = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              bus_req, bus_req_next;
  logic              bus_we, bus_we_next;
  logic [3:0]        bus_sel, bus_sel_next;
  logic [ADDR_W-1:0] bus_addr, bus_addr_next;
  logic [DATA_W-1:0] bus_wdata, bus_wdata_next;
  logic [DATA_W-1:0] if_rdata, if_rdata_next;
  logic [DATA_W-1:0] mem_rdata, mem_rdata_next;
  logic              if_ready, if_ready_next;
  logic              mem_ready, mem_ready_next;
  logic              timeout_err, timeout_err_next;
  logic [CNT_W-1:0]  count, count_next;

  logic             ack;
  logic [CNT_W-1:0] count_inc;
  logic             timed_out;
  logic             mem_eligible;
  logic             if_eligible;

  assign ack       = port.bus_ack & bus_req;
  assign count_inc = count + 1'b1;
  assign timed_out = (count_inc == CNT_W'(TIMEOUT));

  // A requester whose ready is showing this cycle still holds its request;
  // masking it here keeps that stale request from being granted again.
  assign mem_eligible = port.mem_req & ~mem_ready;
  assign if_eligible  = port.if_req & ~port.flush & ~if_ready;

  always_comb begin
    state_next       = state;
    bus_req_next     = bus_req;
    bus_we_next      = bus_we;
    bus_sel_next     = bus_sel;
    bus_addr_next    = bus_addr;
    bus_wdata_next   = bus_wdata;
    if_rdata_next    = if_rdata;
    mem_rdata_next   = mem_rdata;
    if_ready_next    = 1'b0;
    mem_ready_next   = 1'b0;
    timeout_err_next = 1'b0;
    count_next       = count;

    case (state)
      IDLE: begin
        if (mem_eligible) begin
          bus_req_next   = 1'b1;
          bus_we_next    = port.mem_we;
          bus_sel_next   = port.mem_sel;
          bus_addr_next  = port.mem_addr;
          bus_wdata_next = port.mem_wdata;
          count_next     = '0;
          state_next     = MEM_BUSY;
        end else if (if_eligible) begin
          bus_req_next   = 1'b1;
          bus_we_next    = 1'b0;
          bus_sel_next   = 4'hF;
          bus_addr_next  = port.if_addr;
          count_next     = '0;
          state_next     = IF_BUSY;
        end
      end

      MEM_BUSY: begin
        if (ack) begin
          bus_req_next   = 1'b0;
          mem_rdata_next = bus_we ? '0 : port.bus_rdata;
          mem_ready_next = 1'b1;
          state_next     = IDLE;
        end else if (timed_out) begin
          bus_req_next     = 1'b0;
          mem_rdata_next   = '0;
          mem_ready_next   = 1'b1;
          timeout_err_next = 1'b1;
          count_next       = count_inc;
          state_next       = IDLE;
        end else begin
          count_next = count_inc;
        end
      end

      IF_BUSY: begin
        if (ack) begin
          bus_req_next = 1'b0;
          state_next   = IDLE;
          if (!port.flush) begin
            if_rdata_next = port.bus_rdata;
            if_ready_next = 1'b1;
          end
        end else if (timed_out) begin
          bus_req_next = 1'b0;
          count_next   = count_inc;
          state_next   = IDLE;
          if (!port.flush) begin
            if_rdata_next    = '0;
            if_ready_next    = 1'b1;
            timeout_err_next = 1'b1;
          end
        end else begin
          count_next = count_inc;
          if (port.flush) begin
            state_next = IF_DRAIN;
          end
        end
      end

      IF_DRAIN: begin
        // The cancelled fetch must still finish on the bus; its data is dropped.
        if (ack || timed_out) begin
          bus_req_next = 1'b0;
          count_next   = count_inc;
          state_next   = IDLE;
        end else begin
          count_next = count_inc;
        end
      end

      default: begin
        bus_req_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_sel     <= 4'h0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_ready    <= 1'b0;
      mem_ready   <= 1'b0;
      timeout_err <= 1'b0;
      count       <= '0;
    end else begin
      state       <= state_next;
      bus_req     <= bus_req_next;
      bus_we      <= bus_we_next;
      bus_sel     <= bus_sel_next;
      bus_addr    <= bus_addr_next;
      bus_wdata   <= bus_wdata_next;
      if_rdata    <= if_rdata_next;
      mem_rdata   <= mem_rdata_next;
      if_ready    <= if_ready_next;
      mem_ready   <= mem_ready_next;
      timeout_err <= timeout_err_next;
      count       <= count_next;
    end
  end

  assign port.bus_req      = bus_req;
  assign port.bus_we       = bus_we;
  assign port.bus_sel      = bus_sel;
  assign port.bus_addr     = bus_addr;
  assign port.bus_wdata    = bus_wdata;
  assign port.if_rdata     = if_rdata;
  assign port.mem_rdata    = mem_rdata;
  assign port.if_ready     = if_ready;
  assign port.mem_ready    = mem_ready;
  assign port.timeout_err  = timeout_err;
  assign port.stallreq_if  = port.if_req & ~if_ready & ~port.flush;
  assign port.stallreq_mem = port.mem_req & ~mem_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed bench for mem_port_arbiter (TIMEOUT = 8)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic zero_wait;
  logic ack_man;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  // Zero-wait slave acknowledges whenever a cycle is active
  assign bus_if.bus_ack = zero_wait ? bus_if.bus_req : ack_man;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit exp_rdy [9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    bit exp_req [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};

    rst = 1'b1;
    zero_wait = 1'b0;
    ack_man = 1'b0;
    bus_if.flush = 1'b0;
    bus_if.if_req = 1'b0;
    bus_if.if_addr = '0;
    bus_if.mem_req = 1'b0;
    bus_if.mem_we = 1'b0;
    bus_if.mem_sel = 4'h0;
    bus_if.mem_addr = '0;
    bus_if.mem_wdata = '0;
    bus_if.bus_rdata = '0;
    step();
    step();
    chk("rst_bus_req", bus_if.bus_req, 0);
    chk("rst_bus_addr", bus_if.bus_addr, 0);
    chk("rst_mem_ready", bus_if.mem_ready, 0);
    chk("rst_if_ready", bus_if.if_ready, 0);
    chk("rst_mem_rdata", bus_if.mem_rdata, 0);
    chk("rst_timeout", bus_if.timeout_err, 0);
    rst = 1'b0;

    // 1: load with ack three cycles after the grant
    bus_if.mem_req = 1'b1;
    bus_if.mem_we = 1'b0;
    bus_if.mem_sel = 4'hF;
    bus_if.mem_addr = 32'h100;
    #1;
    chk("t1_stall_mem", bus_if.stallreq_mem, 1);
    step();
    chk("t1_bus_req", bus_if.bus_req, 1);
    chk("t1_bus_addr", bus_if.bus_addr, 32'h100);
    chk("t1_bus_we", bus_if.bus_we, 0);
    step();
    step();
    chk("t1_wait_ready", bus_if.mem_ready, 0);
    ack_man = 1'b1;
    bus_if.bus_rdata = 32'hDEADBEEF;
    step();
    ack_man = 1'b0;
    chk("t1_mem_ready", bus_if.mem_ready, 1);
    chk("t1_mem_rdata", bus_if.mem_rdata, 32'hDEADBEEF);
    chk("t1_bus_req_off", bus_if.bus_req, 0);
    chk("t1_stall_off", bus_if.stallreq_mem, 0);
    bus_if.mem_req = 1'b0;
    step();
    chk("t1_ready_pulse", bus_if.mem_ready, 0);
    chk("t1_no_regrant", bus_if.bus_req, 0);

    // 2: simultaneous store and fetch, MEM first
    bus_if.if_req = 1'b1;
    bus_if.if_addr = 32'h200;
    bus_if.mem_req = 1'b1;
    bus_if.mem_we = 1'b1;
    bus_if.mem_sel = 4'b0011;
    bus_if.mem_addr = 32'h300;
    bus_if.mem_wdata = 32'h55AA;
    step();
    chk("t2_bus_we", bus_if.bus_we, 1);
    chk("t2_bus_sel", bus_if.bus_sel, 4'h3);
    chk("t2_bus_addr", bus_if.bus_addr, 32'h300);
    chk("t2_bus_wdata", bus_if.bus_wdata, 32'h55AA);
    chk("t2_stall_if", bus_if.stallreq_if, 1);
    ack_man = 1'b1;
    bus_if.bus_rdata = 32'h12345678;
    step();
    ack_man = 1'b0;
    chk("t2_mem_ready", bus_if.mem_ready, 1);
    chk("t2_store_rdata", bus_if.mem_rdata, 0);
    chk("t2_if_not_ready", bus_if.if_ready, 0);
    step();
    bus_if.mem_req = 1'b0;
    chk("t2_if_grant", bus_if.bus_req, 1);
    chk("t2_if_addr", bus_if.bus_addr, 32'h200);
    chk("t2_if_we", bus_if.bus_we, 0);
    chk("t2_if_sel", bus_if.bus_sel, 4'hF);
    ack_man = 1'b1;
    bus_if.bus_rdata = 32'hCAFEF00D;
    step();
    ack_man = 1'b0;
    chk("t2_if_ready", bus_if.if_ready, 1);
    chk("t2_if_rdata", bus_if.if_rdata, 32'hCAFEF00D);
    bus_if.if_req = 1'b0;
    step();
    chk("t2_if_pulse", bus_if.if_ready, 0);

    // 3: flush of a pending fetch, data drained and discarded
    bus_if.if_req = 1'b1;
    bus_if.if_addr = 32'h400;
    step();
    chk("t3_grant", bus_if.bus_req, 1);
    bus_if.flush = 1'b1;
    #1;
    chk("t3_stall_flush", bus_if.stallreq_if, 0);
    step();
    bus_if.flush = 1'b0;
    bus_if.if_req = 1'b0;
    chk("t3_drain_req", bus_if.bus_req, 1);
    step();
    chk("t3_drain_hold", bus_if.bus_req, 1);
    ack_man = 1'b1;
    bus_if.bus_rdata = 32'h00000BAD;
    step();
    ack_man = 1'b0;
    chk("t3_no_ready", bus_if.if_ready, 0);
    chk("t3_bus_off", bus_if.bus_req, 0);
    chk("t3_rdata_kept", bus_if.if_rdata, 32'hCAFEF00D);
    bus_if.if_req = 1'b1;
    bus_if.if_addr = 32'h500;
    step();
    chk("t3_regrant", bus_if.bus_req, 1);
    chk("t3_regrant_addr", bus_if.bus_addr, 32'h500);
    ack_man = 1'b1;
    bus_if.bus_rdata = 32'h0000600D;
    step();
    ack_man = 1'b0;
    chk("t3_ready", bus_if.if_ready, 1);
    chk("t3_rdata", bus_if.if_rdata, 32'h600D);
    bus_if.if_req = 1'b0;
    step();

    // 4: zero-wait slave, continuous fetch stream
    zero_wait = 1'b1;
    bus_if.bus_rdata = 32'h0F0F0F0F;
    bus_if.if_req = 1'b1;
    bus_if.if_addr = 32'h600;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t4_if_ready_%0d", i), bus_if.if_ready, exp_rdy[i]);
      chk($sformatf("t4_bus_req_%0d", i), bus_if.bus_req, exp_req[i]);
    end
    chk("t4_rdata", bus_if.if_rdata, 32'h0F0F0F0F);
    bus_if.if_req = 1'b0;
    zero_wait = 1'b0;
    step();

    // 5: timeout on a never-acknowledged load (after a load leaves rdata nonzero)
    bus_if.mem_req = 1'b1;
    bus_if.mem_we = 1'b0;
    bus_if.mem_sel = 4'hF;
    bus_if.mem_addr = 32'h680;
    step();
    ack_man = 1'b1;
    bus_if.bus_rdata = 32'h1234;
    step();
    ack_man = 1'b0;
    chk("t5_pre_rdata", bus_if.mem_rdata, 32'h1234);
    bus_if.mem_req = 1'b0;
    step();
    bus_if.mem_req = 1'b1;
    bus_if.mem_addr = 32'h700;
    step();
    chk("t5_grant", bus_if.bus_req, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("t5_busy_%0d", i), bus_if.bus_req, 1);
    end
    chk("t5_no_early_ready", bus_if.mem_ready, 0);
    step();
    chk("t5_abort_req", bus_if.bus_req, 0);
    chk("t5_ready", bus_if.mem_ready, 1);
    chk("t5_timeout_err", bus_if.timeout_err, 1);
    chk("t5_rdata_zero", bus_if.mem_rdata, 0);
    bus_if.mem_req = 1'b0;
    step();
    chk("t5_err_pulse", bus_if.timeout_err, 0);

    // 6: reset in the middle of a load
    bus_if.mem_req = 1'b1;
    bus_if.mem_addr = 32'h800;
    step();
    chk("t6_grant", bus_if.bus_req, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_if.mem_req = 1'b0;
    chk("t6_rst_req", bus_if.bus_req, 0);
    chk("t6_rst_addr", bus_if.bus_addr, 0);
    chk("t6_rst_if_rdata", bus_if.if_rdata, 0);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    chk("t6_late_ack", bus_if.mem_ready, 0);
    chk("t6_idle", bus_if.bus_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
